// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
// The HALT state exists only when FETCH_MISALIGN_CHECK_EN is defined.
package fetch_pkg;

`ifdef FETCH_MISALIGN_CHECK_EN
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HOLD  = 2'd2,
        ST_HALT  = 2'd3
    } fetch_state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HOLD  = 2'd2
    } fetch_state_t;
`endif

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    localparam int OP_LSB     = 0;
    localparam int OP_MSB     = 6;
    localparam int FUNCT3_LSB = 12;
    localparam int FUNCT3_MSB = 14;
    localparam int FUNCT7_BIT = 30;

    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_unit_pc_reg.sv
// Program counter register with redirect load and sequential +4 increment.
module pc_reg
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [31:0] load_value,
    input  logic        incr,
    output logic [31:0] pc
);

    // Redirect wins over increment; +4 wraps naturally at 2^32.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc <= RESET_PC;
        end else if (load) begin
            pc <= load_value;
        end else if (incr) begin
            pc <= pc + 32'd4;
        end else begin
            pc <= pc;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch FSM: requests a word at pc, holds it for decode, handles redirects.
// Optional macro FETCH_MISALIGN_CHECK_EN halts on a misaligned redirect target.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        pc_src,
    input  logic [31:0] pc_target,
    input  logic        instr_ready,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic [31:0] instr_pc_plus4,
    output logic [6:0]  op,
    output logic [2:0]  funct3,
    output logic        funct7,
    output logic        fetch_misaligned
);

    fetch_state_t state;
    logic         kill;
    logic [31:0]  pending;
    logic [31:0]  pc;
    logic         pc_load;
    logic         pc_incr;
    logic [31:0]  pc_load_value;
    logic [31:0]  target_s;
    logic         misalign_s;
    logic         redirect_s;

`ifdef FETCH_MISALIGN_CHECK_EN
    assign misalign_s = pc_src & (pc_target[1:0] != 2'b00);
    assign target_s   = pc_target;
`else
    assign misalign_s = 1'b0;
    assign target_s   = align_word(pc_target);
    assign fetch_misaligned = 1'b0;
`endif
    assign redirect_s = pc_src & ~misalign_s;

    assign imem_addr = pc;
    assign op        = instr[OP_MSB:OP_LSB];
    assign funct3    = instr[FUNCT3_MSB:FUNCT3_LSB];
    assign funct7    = instr[FUNCT7_BIT];

    pc_reg #(.RESET_PC(RESET_PC)) u_pc_reg (
        .clk        (clk),
        .reset      (reset),
        .load       (pc_load),
        .load_value (pc_load_value),
        .incr       (pc_incr),
        .pc         (pc)
    );

    // PC update: the address only moves on ack in FETCH, or when leaving HOLD.
    always_comb begin
        pc_load       = 1'b0;
        pc_incr       = 1'b0;
        pc_load_value = target_s;
        case (state)
            ST_FETCH: begin
                if (imem_ack && redirect_s) begin
                    pc_load = 1'b1;
                end else if (imem_ack && kill) begin
                    pc_load       = 1'b1;
                    pc_load_value = pending;
                end else begin
                    pc_load = 1'b0;
                end
            end
            ST_HOLD: begin
                if (redirect_s) begin
                    pc_load = 1'b1;
                end else if (instr_ready) begin
                    pc_incr = 1'b1;
                end else begin
                    pc_incr = 1'b0;
                end
            end
            default: begin
                pc_load = 1'b0;
            end
        endcase
    end

    // Fetch sequencing, instruction buffer and kill bookkeeping.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= ST_IDLE;
            imem_req       <= 1'b0;
            instr_valid    <= 1'b0;
            instr          <= NOP_INSTR;
            instr_pc       <= RESET_PC;
            instr_pc_plus4 <= RESET_PC + 32'd4;
            kill           <= 1'b0;
            pending        <= RESET_PC;
`ifdef FETCH_MISALIGN_CHECK_EN
            fetch_misaligned <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    state    <= ST_FETCH;
                    imem_req <= 1'b1;
                end
                ST_FETCH: begin
                    if (imem_ack) begin
                        if (redirect_s || kill) begin
                            kill <= 1'b0;
                        end else begin
                            instr          <= imem_rdata;
                            instr_pc       <= pc;
                            instr_pc_plus4 <= pc + 32'd4;
                            instr_valid    <= 1'b1;
                            imem_req       <= 1'b0;
                            state          <= ST_HOLD;
                        end
                    end else if (redirect_s) begin
                        // Address must stay stable until ack, so park the target.
                        kill    <= 1'b1;
                        pending <= target_s;
                    end else begin
                        kill <= kill;
                    end
                end
                ST_HOLD: begin
                    if (redirect_s || instr_ready) begin
                        state       <= ST_FETCH;
                        instr_valid <= 1'b0;
                        imem_req    <= 1'b1;
                    end else begin
                        state <= ST_HOLD;
                    end
                end
`ifdef FETCH_MISALIGN_CHECK_EN
                ST_HALT: begin
                    state <= ST_HALT;
                end
`endif
                default: begin
                    state       <= ST_IDLE;
                    imem_req    <= 1'b0;
                    instr_valid <= 1'b0;
                    kill        <= 1'b0;
                end
            endcase
`ifdef FETCH_MISALIGN_CHECK_EN
            if (misalign_s && (state == ST_FETCH || state == ST_HOLD)) begin
                state            <= ST_HALT;
                imem_req         <= 1'b0;
                instr_valid      <= 1'b0;
                kill             <= 1'b0;
                fetch_misaligned <= 1'b1;
            end else begin
                fetch_misaligned <= fetch_misaligned;
            end
`endif
        end
    end

endmodule
